input_pack_fifo: RTL and testbench

Parametrised byte-serialising input FIFO at the head of the LZRW1 encoder. It accepts words of `IN_BYTES` bytes per cycle with a per-write valid-byte count, so partial (tail) words are supported. It delivers one byte per cycle to the compressor core under a stop/flow-control input. It adds a flush, a sticky overrun flag and a programmable almost-full margin.

---
 rtl/input_pack_fifo.sv | 163 ++++++++++++++++
 tb/tb_input_pack_fifo.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_pack_fifo.sv
// input_pack_fifo
//   Byte-serialising input FIFO at the head of the LZRW1 encoder.
//   Accepts words of IN_BYTES bytes per cycle, each with a valid-byte count,
//   so partial tail words are supported. Emits one byte per cycle under
//   consumer flow control. Also provides flush, a sticky overrun flag and a
//   registered almost-full (busy) indication.
//
// Ports
//   ClkxCI         clock, rising edge
//   RstxRI         asynchronous active-high reset
//   DInxDI         input word, byte 0 in bits [7:0], stored first
//   ByteCntxDI     number of valid bytes in DInxDI, counted from byte 0
//   WExSI          write request
//   FlushxSI       synchronous clear of contents and overrun flag
//   StopOutputxSI  consumer stall, blocks read issue in the same cycle
//   BusyxSO        registered: free space < BUSY_MARGIN
//   DOutxDO        output byte
//   OutStrobexSO   DOutxDO valid this cycle
//   LengthxDO      bytes currently stored (0..DEPTH)
//   OverrunxSO     sticky: a write was rejected
module input_pack_fifo #(
   parameter int IN_BYTES    = 4,
   parameter int DEPTH       = 2048,
   parameter int BUSY_MARGIN = 8
) (
   input  logic                          ClkxCI,
   input  logic                          RstxRI,
   input  logic [8*IN_BYTES-1:0]         DInxDI,
   input  logic [$clog2(IN_BYTES+1)-1:0] ByteCntxDI,
   input  logic                          WExSI,
   input  logic                          FlushxSI,
   input  logic                          StopOutputxSI,
   output logic                          BusyxSO,
   output logic [7:0]                    DOutxDO,
   output logic                          OutStrobexSO,
   output logic [$clog2(DEPTH):0]        LengthxDO,
   output logic                          OverrunxSO
);

   localparam int AW   = $clog2(DEPTH);
   localparam int BW   = $clog2(IN_BYTES);
   localparam int BWX  = (BW > 0) ? BW : 1;
   localparam int ROWS = DEPTH / IN_BYTES;
   localparam int RW   = AW - BW;
   localparam int LW   = AW + 1;
   localparam int CW   = $clog2(IN_BYTES + 1);

   logic [AW-1:0]  WrPtrxDP, WrPtrxDN;
   logic [AW-1:0]  RdPtrxDP, RdPtrxDN;
   logic [LW-1:0]  LengthxDP, LengthxDN;
   logic           BusyxSP, BusyxSN;
   logic           OverrunxSP, OverrunxSN;
   logic           StrobexSP, StrobexSN;
   logic [BWX-1:0] OutBankxDP, OutBankxDN;

   logic           WrAcceptxS, WrRejectxS, ReadIssuexS;
   logic [LW:0]    SpaceNeededxD;
   logic [7:0]     BankOutxD [IN_BYTES];

   // Control: acceptance is judged on the registered length only, so a read
   // in the same cycle never makes room for a write.
   always_comb begin
      SpaceNeededxD = (LW+1)'(LengthxDP) + (LW+1)'(ByteCntxDI);
      WrAcceptxS    = WExSI && !FlushxSI && (ByteCntxDI != '0) &&
                      (ByteCntxDI <= CW'(IN_BYTES)) &&
                      (SpaceNeededxD <= (LW+1)'(DEPTH));
      WrRejectxS    = WExSI && !FlushxSI && (ByteCntxDI != '0) && !WrAcceptxS;
      ReadIssuexS   = (LengthxDP != '0) && !StopOutputxSI && !FlushxSI;

      WrPtrxDN   = WrPtrxDP;
      RdPtrxDN   = RdPtrxDP;
      LengthxDN  = LengthxDP;
      OverrunxSN = OverrunxSP;
      StrobexSN  = 1'b0;
      OutBankxDN = OutBankxDP;
      BusyxSN    = 1'b0;

      if (FlushxSI) begin
         // Output byte register and bank select are left alone so DOutxDO holds.
         WrPtrxDN   = '0;
         RdPtrxDN   = '0;
         LengthxDN  = '0;
         OverrunxSN = 1'b0;
      end else begin
         if (WrAcceptxS)
            WrPtrxDN = WrPtrxDP + AW'(ByteCntxDI);
         if (ReadIssuexS) begin
            RdPtrxDN   = RdPtrxDP + AW'(1);
            OutBankxDN = BWX'(int'(RdPtrxDP) & (IN_BYTES - 1));
         end
         LengthxDN  = LengthxDP + (WrAcceptxS ? LW'(ByteCntxDI) : '0) - LW'(ReadIssuexS);
         OverrunxSN = OverrunxSP | WrRejectxS;
         StrobexSN  = ReadIssuexS;
         BusyxSN    = (LengthxDN > LW'(DEPTH - BUSY_MARGIN));
      end
   end

   always_ff @(posedge ClkxCI or posedge RstxRI) begin
      if (RstxRI) begin
         WrPtrxDP   <= '0;
         RdPtrxDP   <= '0;
         LengthxDP  <= '0;
         BusyxSP    <= 1'b0;
         OverrunxSP <= 1'b0;
         StrobexSP  <= 1'b0;
         OutBankxDP <= '0;
      end else begin
         WrPtrxDP   <= WrPtrxDN;
         RdPtrxDP   <= RdPtrxDN;
         LengthxDP  <= LengthxDN;
         BusyxSP    <= BusyxSN;
         OverrunxSP <= OverrunxSN;
         StrobexSP  <= StrobexSN;
         OutBankxDP <= OutBankxDN;
      end
   end

   // Byte address A lives in bank A mod IN_BYTES, row A / IN_BYTES. For each
   // bank, the input byte landing there is the one whose offset from WP maps
   // to this bank; that offset must be below the byte count to be written.
   for (genvar gi = 0; gi < IN_BYTES; gi++) begin : gBank
      logic [7:0]    MemxD [0:ROWS-1];
      int            OffsetxD;
      logic [AW-1:0] WrAddrxD;
      logic [RW-1:0] WrRowxD, RdRowxD;
      logic [7:0]    WrDataxD;
      logic          WrEnxS, RdEnxS;
      logic [7:0]    RdDataxDP;

      always_comb begin
         OffsetxD = (gi - int'(WrPtrxDP)) & (IN_BYTES - 1);
         WrAddrxD = WrPtrxDP + AW'(OffsetxD);
         WrRowxD  = RW'(WrAddrxD >> BW);
         RdRowxD  = RW'(RdPtrxDP >> BW);
         WrDataxD = DInxDI[8*OffsetxD +: 8];
         WrEnxS   = WrAcceptxS && (OffsetxD < int'(ByteCntxDI));
         RdEnxS   = ReadIssuexS && ((int'(RdPtrxDP) & (IN_BYTES - 1)) == gi);
      end

      always_ff @(posedge ClkxCI) begin
         if (WrEnxS)
            MemxD[WrRowxD] <= WrDataxD;
      end

      // Registered read port; only the bank holding RP is loaded, so the
      // selected bank output keeps the last byte when no read is issued.
      always_ff @(posedge ClkxCI or posedge RstxRI) begin
         if (RstxRI)
            RdDataxDP <= '0;
         else if (RdEnxS)
            RdDataxDP <= MemxD[RdRowxD];
      end

      assign BankOutxD[gi] = RdDataxDP;
   end

   assign DOutxDO      = BankOutxD[OutBankxDP];
   assign OutStrobexSO = StrobexSP;
   assign LengthxDO    = LengthxDP;
   assign BusyxSO      = BusyxSP;
   assign OverrunxSO   = OverrunxSP;

endmodule

// File: tb/tb_input_pack_fifo.sv
module tb_input_pack_fifo;
   localparam int IB = 4;
   localparam int D  = 2048;
   localparam int M  = 8;
   localparam int CW = $clog2(IB + 1);

   logic            ClkxCI = 1'b0;
   logic            RstxRI = 1'b1;
   logic [8*IB-1:0] DInxDI = '0;
   logic [CW-1:0]   ByteCntxDI = '0;
   logic            WExSI = 1'b0;
   logic            FlushxSI = 1'b0;
   logic            StopOutputxSI = 1'b0;
   logic            BusyxSO;
   logic [7:0]      DOutxDO;
   logic            OutStrobexSO;
   logic [$clog2(D):0] LengthxDO;
   logic            OverrunxSO;

   input_pack_fifo #(.IN_BYTES(IB), .DEPTH(D), .BUSY_MARGIN(M)) dut (
      .ClkxCI(ClkxCI), .RstxRI(RstxRI), .DInxDI(DInxDI), .ByteCntxDI(ByteCntxDI),
      .WExSI(WExSI), .FlushxSI(FlushxSI), .StopOutputxSI(StopOutputxSI),
      .BusyxSO(BusyxSO), .DOutxDO(DOutxDO), .OutStrobexSO(OutStrobexSO),
      .LengthxDO(LengthxDO), .OverrunxSO(OverrunxSO)
   );

   always #5 ClkxCI = ~ClkxCI;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: a plain byte queue plus expected registered outputs.
   logic [7:0] mQ[$];
   logic [7:0] expDout = 8'h00;
   bit expStrobe = 0, expBusy = 0, expOv = 0;

   // Observed output stream.
   logic [7:0] obsQ[$];
   int obsCyc[$];
   logic [7:0] wrQ[$];

   task automatic model_clear();
      mQ.delete();
      expDout = 8'h00; expStrobe = 0; expBusy = 0; expOv = 0;
   endtask

   // One clock cycle: drive inputs, advance model, sample outputs #1 after edge.
   task automatic step(input bit we, input int n, input logic [31:0] din,
                       input bit stop, input bit flush);
      int sz;
      bit acc;
      WExSI = we; ByteCntxDI = CW'(n); DInxDI = din;
      StopOutputxSI = stop; FlushxSI = flush;
      @(posedge ClkxCI);
      sz = mQ.size();
      if (flush) begin
         mQ.delete();
         expOv = 0; expStrobe = 0; expBusy = 0;
      end else begin
         acc = we && n >= 1 && n <= IB && (sz + n) <= D;
         if (we && n != 0 && !acc) expOv = 1;
         expStrobe = (sz > 0) && !stop;
         if (expStrobe) expDout = mQ.pop_front();
         if (acc) for (int i = 0; i < n; i++) mQ.push_back(din[8*i +: 8]);
         expBusy = mQ.size() > (D - M);
      end
      cyc++;
      #1;
      if (OutStrobexSO) begin
         obsQ.push_back(DOutxDO);
         obsCyc.push_back(cyc);
      end
      WExSI = 1'b0; FlushxSI = 1'b0; ByteCntxDI = '0;
   endtask

   task automatic put_word(input int n, input bit stop);
      logic [31:0] d;
      d = $urandom;
      for (int i = 0; i < n; i++) wrQ.push_back(d[8*i +: 8]);
      step(1, n, d, stop, 0);
   endtask

   task automatic compare_stream(input string name);
      checks++;
      if (obsQ.size() !== wrQ.size()) begin
         errors++;
         $display("FAIL %s count got %0d exp %0d", name, obsQ.size(), wrQ.size());
      end
      for (int i = 0; i < obsQ.size() && i < wrQ.size(); i++) begin
         checks++;
         if (obsQ[i] !== wrQ[i]) begin
            errors++;
            $display("FAIL %s byte %0d got %02h exp %02h", name, i, obsQ[i], wrQ[i]);
         end
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({LengthxDO, BusyxSO, OverrunxSO, OutStrobexSO, DOutxDO} !== '0) begin
         errors++;
         $display("FAIL reset_state got len=%0d busy=%b ov=%b stb=%b dout=%02h exp all 0",
                  LengthxDO, BusyxSO, OverrunxSO, OutStrobexSO, DOutxDO);
      end
      repeat (2) @(posedge ClkxCI);
      @(negedge ClkxCI);
      RstxRI = 1'b0;
      model_clear();
      $display("reset released at cycle %0d", cyc);
   endtask

   task automatic test_single_word();
      logic [7:0] exp_b [4];
      exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
      step(1, 4, 32'h44332211, 0, 0);
      $display("write n=4 data=44332211 len=%0d", LengthxDO);
      checks++;
      if (LengthxDO !== 4 || OutStrobexSO !== 1'b0) begin
         errors++;
         $display("FAIL single_len1 got len=%0d stb=%b exp len=4 stb=0", LengthxDO, OutStrobexSO);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0);
         $display("out cycle %0d stb=%b dout=%02h", cyc, OutStrobexSO, DOutxDO);
         checks++;
         if (OutStrobexSO !== 1'b1 || DOutxDO !== exp_b[i]) begin
            errors++;
            $display("FAIL single_byte%0d got stb=%b dout=%02h exp stb=1 dout=%02h",
                     i, OutStrobexSO, DOutxDO, exp_b[i]);
         end
      end
      checks++;
      if (LengthxDO !== 0) begin
         errors++;
         $display("FAIL single_len_end got %0d exp 0", LengthxDO);
      end
      step(0, 0, 0, 0, 0);
      checks++;
      if (OutStrobexSO !== 1'b0 || DOutxDO !== 8'h44) begin
         errors++;
         $display("FAIL single_idle got stb=%b dout=%02h exp stb=0 dout=44", OutStrobexSO, DOutxDO);
      end
   endtask

   task automatic test_partial();
      obsQ.delete(); obsCyc.delete(); wrQ.delete();
      wrQ = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      step(1, 3, 32'hEECCBBAA, 0, 0);
      $display("write n=3 data=EECCBBAA");
      step(1, 1, 32'h123456DD, 0, 0);
      $display("write n=1 data=123456DD");
      repeat (6) step(0, 0, 0, 0, 0);
      compare_stream("partial");
      for (int i = 1; i < obsCyc.size(); i++) begin
         checks++;
         if (obsCyc[i] !== obsCyc[i-1] + 1) begin
            errors++;
            $display("FAIL partial_gap at %0d got cycle %0d exp %0d", i, obsCyc[i], obsCyc[i-1] + 1);
         end
      end
   endtask

   task automatic test_fill();
      step(0, 0, 0, 1, 1);
      obsQ.delete(); wrQ.delete();
      for (int w = 0; w < D / IB; w++) begin
         put_word(4, 1);
         checks++;
         if (LengthxDO !== 4 * (w + 1) || BusyxSO !== (4 * (w + 1) > D - M)) begin
            errors++;
            $display("FAIL fill_w%0d got len=%0d busy=%b exp len=%0d busy=%b",
                     w, LengthxDO, BusyxSO, 4 * (w + 1), (4 * (w + 1) > D - M));
         end
      end
      $display("fill done len=%0d busy=%b", LengthxDO, BusyxSO);
      step(1, 4, 32'hDEADBEEF, 1, 0);
      $display("write n=4 when full ov=%b len=%0d", OverrunxSO, LengthxDO);
      checks++;
      if (OverrunxSO !== 1'b1 || LengthxDO !== D) begin
         errors++;
         $display("FAIL fill_overrun got ov=%b len=%0d exp ov=1 len=%0d", OverrunxSO, LengthxDO, D);
      end
      repeat (D + 3) step(0, 0, 0, 0, 0);
      compare_stream("fill_drain");
      checks++;
      if (LengthxDO !== 0 || BusyxSO !== 1'b0) begin
         errors++;
         $display("FAIL fill_empty got len=%0d busy=%b exp 0 0", LengthxDO, BusyxSO);
      end
   endtask

   task automatic test_wrap();
      step(0, 0, 0, 1, 1);
      for (int w = 0; w < 511; w++) step(1, 4, $urandom, 1, 0);
      step(1, 2, $urandom, 1, 0);
      repeat (D) step(0, 0, 0, 0, 0);
      checks++;
      if (LengthxDO !== 0) begin
         errors++;
         $display("FAIL wrap_offset got len=%0d exp 0", LengthxDO);
      end
      obsQ.delete(); wrQ.delete();
      for (int j = 0; j < 30; j++) begin
         put_word(4, 0);
         checks++;
         if (LengthxDO !== 4 + 3 * j) begin
            errors++;
            $display("FAIL wrap_len%0d got %0d exp %0d", j, LengthxDO, 4 + 3 * j);
         end
      end
      $display("wrap stream done len=%0d", LengthxDO);
      repeat (100) step(0, 0, 0, 0, 0);
      compare_stream("wrap");
   endtask

   task automatic test_stop();
      step(0, 0, 0, 0, 1);
      obsQ.delete(); wrQ.delete();
      for (int j = 0; j < 20; j++) put_word(4, 0);
      checks++;
      if (OutStrobexSO !== 1'b1) begin
         errors++;
         $display("FAIL stop_pre got stb=%b exp 1", OutStrobexSO);
      end
      for (int j = 0; j < 3; j++) begin
         step(0, 0, 0, 1, 0);
         $display("stop cycle %0d stb=%b", cyc, OutStrobexSO);
         checks++;
         if (OutStrobexSO !== 1'b0) begin
            errors++;
            $display("FAIL stop_hold%0d got stb=%b exp 0", j, OutStrobexSO);
         end
      end
      step(0, 0, 0, 0, 0);
      checks++;
      if (OutStrobexSO !== 1'b1 || DOutxDO !== expDout) begin
         errors++;
         $display("FAIL stop_resume got stb=%b dout=%02h exp stb=1 dout=%02h",
                  OutStrobexSO, DOutxDO, expDout);
      end
      repeat (80) step(0, 0, 0, 0, 0);
      compare_stream("stop");
   endtask

   task automatic test_random();
      bit we, stop, flush;
      int n;
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 400; i++) begin
         we    = ($urandom % 3) != 0;
         n     = $urandom_range(0, 5);
         stop  = ($urandom % 4) == 0;
         flush = ($urandom % 60) == 0;
         step(we, n, $urandom, stop, flush);
         checks++;
         if (LengthxDO !== mQ.size() || BusyxSO !== expBusy || OverrunxSO !== expOv ||
             OutStrobexSO !== expStrobe || DOutxDO !== expDout) begin
            errors++;
            $display("FAIL random_%0d got len=%0d busy=%b ov=%b stb=%b dout=%02h exp len=%0d busy=%b ov=%b stb=%b dout=%02h",
                     i, LengthxDO, BusyxSO, OverrunxSO, OutStrobexSO, DOutxDO,
                     mQ.size(), expBusy, expOv, expStrobe, expDout);
         end
      end
      $display("random done len=%0d", LengthxDO);
   endtask

   task automatic test_flush_reset();
      step(0, 0, 0, 1, 1);
      for (int w = 0; w < 25; w++) step(1, 4, $urandom, 1, 0);
      step(1, 5, 32'h01020304, 1, 0);
      checks++;
      if (OverrunxSO !== 1'b1 || LengthxDO !== 100) begin
         errors++;
         $display("FAIL flush_pre got ov=%b len=%0d exp ov=1 len=100", OverrunxSO, LengthxDO);
      end
      step(1, 4, 32'hAABBCCDD, 0, 1);
      $display("flush at cycle %0d len=%0d", cyc, LengthxDO);
      checks++;
      if (LengthxDO !== 0 || OverrunxSO !== 1'b0 || OutStrobexSO !== 1'b0 ||
          BusyxSO !== 1'b0 || DOutxDO !== expDout) begin
         errors++;
         $display("FAIL flush_post got len=%0d ov=%b stb=%b busy=%b dout=%02h exp 0 0 0 0 dout=%02h",
                  LengthxDO, OverrunxSO, OutStrobexSO, BusyxSO, DOutxDO, expDout);
      end
      for (int w = 0; w < 6; w++) step(1, 4, $urandom, 0, 0);
      WExSI = 1'b1; ByteCntxDI = CW'(4); DInxDI = 32'h55667788;
      @(negedge ClkxCI);
      RstxRI = 1'b1;
      #1;
      checks++;
      if ({LengthxDO, BusyxSO, OverrunxSO, OutStrobexSO, DOutxDO} !== '0) begin
         errors++;
         $display("FAIL async_reset got len=%0d busy=%b ov=%b stb=%b dout=%02h exp all 0",
                  LengthxDO, BusyxSO, OverrunxSO, OutStrobexSO, DOutxDO);
      end
      @(posedge ClkxCI);
      #1;
      checks++;
      if (LengthxDO !== 0) begin
         errors++;
         $display("FAIL reset_hold got len=%0d exp 0", LengthxDO);
      end
      @(negedge ClkxCI);
      RstxRI = 1'b0; WExSI = 1'b0;
      model_clear();
      step(0, 0, 0, 0, 0);
      checks++;
      if (LengthxDO !== 0 || OutStrobexSO !== 1'b0) begin
         errors++;
         $display("FAIL reset_after got len=%0d stb=%b exp 0 0", LengthxDO, OutStrobexSO);
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_partial();
      test_fill();
      test_wrap();
      test_stop();
      test_random();
      test_flush_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
